led_io_bridge: RTL and testbench

- Memory-mapped write bridge between the CPU store path (MemOrIO) and the 24-bit LED output register.
- Decodes stores to the LED address window, buffers them in a small FIFO, and splits word/half/byte stores into single-cycle 16-bit strobes: a low strobe for LED[15:0], a high strobe for LED[23:16].
- Keeps a shadow copy of the LED value. Byte stores are merged against the shadow, so unwritten LED bits are preserved.

---
 rtl/led_io_bridge.sv | 165 ++++++++++++++++
 tb/tb_led_io_bridge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/led_io_bridge.sv
// led_io_bridge: write bridge from the CPU store path (MemOrIO) to the
// 24-bit LED output register.
//
// Stores that fall in the LED window are decoded into 16-bit strobe entries.
// The entries are queued in a small FIFO and issued one per cycle as
// registered strobes: LEDCtrllow loads ledwdata into LED[15:0], and
// LEDCtrlhigh loads ledwdata[7:0] into LED[23:16]. Partial stores are merged
// against a shadow copy of the LED value, so LED bits that were not written
// keep their old value.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   io_wr         store request, valid this cycle
//   io_addr       store byte address
//   io_size       00 byte, 01 half, 10 word, 11 illegal
//   io_wdata      store data, right-aligned
//   io_ready      a store can be accepted this cycle (room for two entries)
//   io_err        one-cycle pulse after an LED-window store is rejected
//   LEDCtrllow    strobe: load ledwdata into LED[15:0]
//   LEDCtrlhigh   strobe: load ledwdata[7:0] into LED[23:16]
//   ledwdata      data for the LED register
//   led_shadow    shadow of the LED value, one cycle ahead of the LED register
//   pending       FIFO occupancy
module led_io_bridge #(
  parameter logic [31:0] LED_BASE   = 32'hFFFF_FC60,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [1:0]  io_size,
  input  logic [31:0] io_wdata,
  output logic        io_ready,
  output logic        io_err,
  output logic        LEDCtrllow,
  output logic        LEDCtrlhigh,
  output logic [15:0] ledwdata,
  output logic [23:0] led_shadow,
  output logic [2:0]  pending
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] READY_MAX = 3'(FIFO_DEPTH - 2);

  typedef enum logic {SEL_LOW = 1'b0, SEL_HIGH = 1'b1} sel_t;

  typedef struct packed {
    sel_t        sel;
    logic [1:0]  mask;
    logic [15:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_p1;
  logic [2:0]    count;

  logic          hit, accept, bad, pop;
  logic [1:0]    n_push, push_cnt;
  entry_t        e0, e1, head;
  logic [15:0]   cur, merged;

  // Bits 31:24 of a word store have no LED bits to land in.
  logic          unused_wdata;
  assign unused_wdata = ^io_wdata[31:24];

  assign hit      = (io_addr[31:2] == LED_BASE[31:2]);
  assign io_ready = (count <= READY_MAX);
  assign accept   = io_wr && hit && io_ready;
  assign pending  = count;

  // Store decode into zero, one or two FIFO entries.
  always_comb begin
    n_push  = 2'd0;
    bad     = 1'b0;
    e0      = '0;
    e1      = '0;
    unique case (io_size)
      2'b10: begin
        if (io_addr[1:0] == 2'd0) begin
          n_push  = 2'd2;
          e0.sel  = SEL_LOW;
          e0.mask = 2'b11;
          e0.data = io_wdata[15:0];
          e1.sel  = SEL_HIGH;
          e1.mask = 2'b01;
          e1.data = {8'h00, io_wdata[23:16]};
        end else begin
          bad = 1'b1;
        end
      end
      2'b01: begin
        unique case (io_addr[1:0])
          2'd0: begin
            n_push = 2'd1; e0.sel = SEL_LOW;  e0.mask = 2'b11; e0.data = io_wdata[15:0];
          end
          2'd2: begin
            n_push = 2'd1; e0.sel = SEL_HIGH; e0.mask = 2'b01; e0.data = {8'h00, io_wdata[7:0]};
          end
          default: bad = 1'b1;
        endcase
      end
      2'b00: begin
        unique case (io_addr[1:0])
          2'd0: begin
            n_push = 2'd1; e0.sel = SEL_LOW;  e0.mask = 2'b01; e0.data = {8'h00, io_wdata[7:0]};
          end
          2'd1: begin
            n_push = 2'd1; e0.sel = SEL_LOW;  e0.mask = 2'b10; e0.data = {io_wdata[7:0], 8'h00};
          end
          2'd2: begin
            n_push = 2'd1; e0.sel = SEL_HIGH; e0.mask = 2'b01; e0.data = {8'h00, io_wdata[7:0]};
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  assign push_cnt  = accept ? n_push : 2'd0;
  assign pop       = (count != 3'd0);
  assign wr_ptr_p1 = wr_ptr + AW'(1);
  assign head      = mem[rd_ptr];

  // Merging at issue time means the shadow already reflects every earlier
  // store, including those that were still queued when this one was accepted.
  always_comb begin
    cur    = (head.sel == SEL_LOW) ? led_shadow[15:0] : {8'h00, led_shadow[23:16]};
    merged = cur;
    if (head.mask[0]) merged[7:0]  = head.data[7:0];
    if (head.mask[1]) merged[15:8] = head.data[15:8];
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr]    <= e0;
    if (push_cnt == 2'd2) mem[wr_ptr_p1] <= e1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      io_err      <= 1'b0;
      LEDCtrllow  <= 1'b0;
      LEDCtrlhigh <= 1'b0;
      ledwdata    <= '0;
      led_shadow  <= '0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(push_cnt);
      count       <= count + {1'b0, push_cnt} - {2'b00, pop};
      io_err      <= io_wr && hit && io_ready && bad;
      LEDCtrllow  <= pop && (head.sel == SEL_LOW);
      LEDCtrlhigh <= pop && (head.sel == SEL_HIGH);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        ledwdata <= merged;
        if (head.sel == SEL_LOW) led_shadow[15:0]  <= merged;
        else                     led_shadow[23:16] <= merged[7:0];
      end
    end
  end

endmodule

// File: tb/tb_led_io_bridge.sv
// tb_led_io_bridge: directed self-checking bench for led_io_bridge.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_led_io_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_FC60;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_wr;
  logic [31:0] io_addr;
  logic [1:0]  io_size;
  logic [31:0] io_wdata;
  logic        io_ready, io_err, LEDCtrllow, LEDCtrlhigh;
  logic [15:0] ledwdata;
  logic [23:0] led_shadow;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  led_io_bridge #(.LED_BASE(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .io_wr(io_wr), .io_addr(io_addr), .io_size(io_size),
    .io_wdata(io_wdata), .io_ready(io_ready), .io_err(io_err),
    .LEDCtrllow(LEDCtrllow), .LEDCtrlhigh(LEDCtrlhigh), .ledwdata(ledwdata),
    .led_shadow(led_shadow), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    io_wr = 1'b1; io_addr = a; io_size = s; io_wdata = d;
  endtask

  task automatic idle();
    io_wr = 1'b0; io_addr = '0; io_size = '0; io_wdata = '0;
  endtask

  // Strobe state: low, high, data.
  task automatic strobe(input string tag, input logic l, input logic h, input logic [15:0] d);
    chk({tag, "_low"},  {31'd0, LEDCtrllow},  {31'd0, l});
    chk({tag, "_high"}, {31'd0, LEDCtrlhigh}, {31'd0, h});
    chk({tag, "_data"}, {16'd0, ledwdata},    {16'd0, d});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    strobe("rst", 1'b0, 1'b0, 16'h0000);
    chk("rst_shadow", {8'd0, led_shadow}, 32'd0);
    chk("rst_err", {31'd0, io_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, io_ready}, 32'd1);

    // Word store: low strobe then high strobe.
    put(BASE, 2'b10, 32'h00A5_1234);
    @(negedge clk); idle();
    chk("w_pend2", {29'd0, pending}, 32'd2);
    chk("w_nolow", {31'd0, LEDCtrllow}, 32'd0);
    @(negedge clk);
    strobe("w_l", 1'b1, 1'b0, 16'h1234);
    chk("w_pend1", {29'd0, pending}, 32'd1);
    @(negedge clk);
    strobe("w_h", 1'b0, 1'b1, 16'h00A5);
    chk("w_shadow", {8'd0, led_shadow}, 32'h00A5_1234);
    chk("w_pend0", {29'd0, pending}, 32'd0);
    @(negedge clk);
    strobe("w_idle", 1'b0, 1'b0, 16'h00A5);

    // Back-to-back byte stores merged against the shadow.
    put(BASE + 32'd1, 2'b00, 32'h0000_0077);
    @(negedge clk);
    chk("b_pend1", {29'd0, pending}, 32'd1);
    put(BASE + 32'd2, 2'b00, 32'h0000_005C);
    @(negedge clk); idle();
    strobe("b1", 1'b1, 1'b0, 16'h7734);
    chk("b_pend_pp", {29'd0, pending}, 32'd1);
    @(negedge clk);
    strobe("b2", 1'b0, 1'b1, 16'h005C);
    chk("b_shadow", {8'd0, led_shadow}, 32'h005C_7734);
    @(negedge clk);
    chk("b_pend0", {29'd0, pending}, 32'd0);

    // Three word stores: back-pressure at pending=3, gapless L,H,L,H,L,H.
    put(BASE, 2'b10, 32'h0011_2233);
    @(negedge clk);
    chk("f_pend_a", {29'd0, pending}, 32'd2);
    chk("f_ready_a", {31'd0, io_ready}, 32'd1);
    put(BASE, 2'b10, 32'hFF44_5566);
    @(negedge clk);
    chk("f_pend_b", {29'd0, pending}, 32'd3);
    chk("f_ready_b", {31'd0, io_ready}, 32'd0);
    strobe("f1", 1'b1, 1'b0, 16'h2233);
    put(BASE, 2'b10, 32'h0077_8899);
    @(negedge clk);
    chk("f_pend_c", {29'd0, pending}, 32'd2);
    chk("f_ready_c", {31'd0, io_ready}, 32'd1);
    strobe("f2", 1'b0, 1'b1, 16'h0011);
    @(negedge clk); idle();
    chk("f_pend_d", {29'd0, pending}, 32'd3);
    strobe("f3", 1'b1, 1'b0, 16'h5566);
    @(negedge clk);
    strobe("f4", 1'b0, 1'b1, 16'h0044);
    @(negedge clk);
    strobe("f5", 1'b1, 1'b0, 16'h8899);
    @(negedge clk);
    strobe("f6", 1'b0, 1'b1, 16'h0077);
    chk("f_pend_e", {29'd0, pending}, 32'd0);
    @(negedge clk);
    strobe("f_idle", 1'b0, 1'b0, 16'h0077);
    chk("f_shadow", {8'd0, led_shadow}, 32'h0077_8899);

    // Illegal LED-window stores: one-cycle io_err, nothing queued.
    put(BASE + 32'd1, 2'b01, 32'h0000_ABCD);
    @(negedge clk); idle();
    chk("e1_err", {31'd0, io_err}, 32'd1);
    chk("e1_pend", {29'd0, pending}, 32'd0);
    @(negedge clk);
    chk("e1_clr", {31'd0, io_err}, 32'd0);
    put(BASE + 32'd2, 2'b10, 32'h1234_5678);
    @(negedge clk); idle();
    chk("e2_err", {31'd0, io_err}, 32'd1);
    @(negedge clk);
    chk("e2_clr", {31'd0, io_err}, 32'd0);
    put(BASE, 2'b11, 32'h1234_5678);
    @(negedge clk); idle();
    chk("e3_err", {31'd0, io_err}, 32'd1);
    chk("e3_pend", {29'd0, pending}, 32'd0);
    @(negedge clk);
    chk("e3_clr", {31'd0, io_err}, 32'd0);
    strobe("e_none", 1'b0, 1'b0, 16'h0077);
    chk("e_shadow", {8'd0, led_shadow}, 32'h0077_8899);

    // Stores outside the window: ignored silently.
    put(BASE + 32'd8, 2'b10, 32'h00FF_FFFF);
    @(negedge clk);
    chk("m1_err", {31'd0, io_err}, 32'd0);
    chk("m1_pend", {29'd0, pending}, 32'd0);
    put(32'h0000_0010, 2'b10, 32'h00FF_FFFF);
    @(negedge clk); idle();
    chk("m2_err", {31'd0, io_err}, 32'd0);
    chk("m2_pend", {29'd0, pending}, 32'd0);
    @(negedge clk);
    strobe("m_none", 1'b0, 1'b0, 16'h0077);
    chk("m_shadow", {8'd0, led_shadow}, 32'h0077_8899);

    // Reset during the low strobe of a word store.
    put(BASE, 2'b10, 32'h0012_3456);
    @(negedge clk); idle();
    @(negedge clk);
    strobe("r_l", 1'b1, 1'b0, 16'h3456);
    rst = 1'b1;
    #1;
    strobe("r_async", 1'b0, 1'b0, 16'h0000);
    chk("r_shadow", {8'd0, led_shadow}, 32'd0);
    chk("r_pend", {29'd0, pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      strobe("r_after", 1'b0, 1'b0, 16'h0000);
      chk("r_after_pend", {29'd0, pending}, 32'd0);
    end

    // Byte store at offset 0 onto a cleared shadow.
    put(BASE, 2'b00, 32'h0000_00AB);
    @(negedge clk); idle();
    @(negedge clk);
    strobe("b0", 1'b1, 1'b0, 16'h00AB);
    chk("b0_shadow", {8'd0, led_shadow}, 32'h0000_00AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
